dmem_dma: RTL and testbench
===========================

# dmem_dma

Word-granular DMA initiator that drives the data-memory port (address, write enable, write data, combinational read data). It moves RSA operand blocks inside data memory without CPU load/store traffic. A shared-port arbiter grants it the port. Software programs source, destination, length and mode, then pulses `start`. The engine reports `busy`, a one-cycle `done` and a sticky `err`.

## Interface
Parameters:
- LEN_W, 8, width of the word-count field; maximum transfer is 2^LEN_W − 1 words.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset values below immediately.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill (fill exists only with `DMEM_DMA_FILL_EN`).
- src  in  32  source byte address for copy; must be word aligned.
- dst  in  32  destination byte address; must be word aligned.
- len  in  LEN_W  transfer length in words.
- fill_val  in  32  word written in fill mode.
- mem_grant  in  1  arbiter grant; the engine advances only when it is high.
- mem_rd  in  32  memory read data, combinational from `mem_a`.
- mem_a  out  32  memory byte address.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- busy  out  1  high while a transfer is in RD or WR.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky alignment error; cleared by the next accepted `start`.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE, with `start`=1:
  - On accept, latch `src`, `dst`, `len`, `mode` and `fill_val`, and clear `err`.
  - Misaligned address (src[1:0] ≠ 0 in copy mode, or dst[1:0] ≠ 0): set `err`, go to FIN, no memory access.
  - `len`=0: go to FIN, no memory access.
  - Otherwise: copy mode goes to RD; fill mode goes to WR.
- RD:
  - `mem_a` = src pointer and `mem_we` = 0.
  - If `mem_grant`=1: capture `mem_rd` into the data register and go to WR. Otherwise hold.
- WR:
  - `mem_a` = dst pointer and `mem_wd` = data register (copy) or `fill_val` (fill).
  - `mem_we` = `mem_grant`.
  - If `mem_grant`=1: src and dst pointers each +4, remaining count −1.
    - If the remaining count was 1, go to FIN.
    - Otherwise go to RD (copy) or stay in WR (fill).
  - Otherwise hold.
- FIN: `done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^32. Wrap-around is not an error; memory-side aliasing applies.
- Overlapping regions are copied in ascending address order. With dst > src and overlap, the result is a forward-smear, and this is the specified behaviour.
- `start` in any state other than IDLE is ignored; there is no queuing.

## Timing
- Reset values: `mem_a`=0, `mem_we`=0, `mem_wd`=0, `busy`=0, `done`=0, `err`=0, state IDLE, pointers and count 0.
- `mem_we` is combinational from (state==WR) & `mem_grant`. Every other output is registered or decoded from state.
- Timing below assumes `start` sampled in cycle 0 and `mem_grant` held at 1:
  - Copy of N words: `busy` high in cycles 1..2N; writes occur in the even cycles 2, 4, …, 2N; `done` is high in cycle 2N+1.
  - Fill of N words: `busy` high in cycles 1..N, with one write per cycle; `done` is high in cycle N+1.
  - `len`=0 or a misaligned address: `done` (and `err` if misaligned) is high in cycle 1; `busy` never rises.
- Each cycle with `mem_grant`=0 in RD or WR adds exactly one cycle and leaves all state unchanged.
- `reset` asserted mid-transfer returns to IDLE asynchronously and drops `mem_we` in the same cycle. Words already written stay written, and no `done` pulse is produced.
- `start` in the `done` cycle is ignored; it is accepted from the following cycle, in IDLE.

## Configuration
- `DMEM_DMA_FILL_EN` defined: fill mode is compiled in, and `mode`=1 behaves as described above.
- `DMEM_DMA_FILL_EN` undefined:
  - The fill datapath and `fill_val` logic are removed.
  - `mode` is ignored and every request is a copy; `fill_val` is an unused input.

## Test plan
- Copy: memory words 0x10..0x18 hold 0x11, 0x22, 0x33; copy src=0x10, dst=0x40, len=3 with grant held high. Required: words 0x40, 0x44, 0x48 read 0x11, 0x22, 0x33; `busy` high in cycles 1–6; `done` in cycle 7; `err`=0.
- Fill (FILL_EN defined): fill dst=0x80, len=4, fill_val=0xDEADBEEF. Required: words 0x80..0x8C all read 0xDEADBEEF; `done` in cycle 5.
- Grant stall: copy len=2, with grant dropped for 3 cycles during the first WR. Required: `mem_we`=0 during the stall; correct data afterwards; `done` in cycle 8.
- Zero length and misalignment:
  - len=0: `done` in cycle 1, with no `mem_we` ever.
  - src=0x12: `err`=1 and `done` in cycle 1, with no access; the next valid `start` clears `err`.
- Reset mid-transfer: copy len=4, with `reset` asserted after the 2nd write. Required: `mem_we`, `busy` and `done` all drop to 0 immediately; exactly 2 destination words are modified.
- Ignored start: with FILL_EN undefined, `mode`=1 results in a copy; a `start` pulse while `busy` changes neither the latched parameters nor the timing.

Source files
------------

// File: rtl/dmem_dma.sv
// dmem_dma: word-granular DMA initiator for the data-memory port.
// It moves operand blocks inside data memory without CPU load/store traffic,
// advancing only while the shared-port arbiter grants the port.
//
// Optional feature macro: DMEM_DMA_FILL_EN
//   defined   -> mode=1 fills the destination with fill_val
//   undefined -> mode and fill_val are ignored, every request is a copy
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          request pulse, sampled only in IDLE
//   mode           0 = copy, 1 = fill
//   src, dst       word-aligned byte addresses
//   len            transfer length in words
//   fill_val       word written in fill mode
//   mem_grant      arbiter grant
//   mem_rd         combinational read data for mem_a
//   mem_a/we/wd    memory address, write enable, write data
//   busy           high in RD or WR
//   done           one-cycle completion pulse
//   err            sticky alignment error, cleared by the next accepted start
//
// state | meaning
// ------+----------------------------------------------------
// IDLE  | waiting for start
// RD    | reading the source word into the data register
// WR    | writing one word to the destination
// FIN   | done pulse, back to IDLE next cycle

module dmem_dma #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_val,
    input  logic             mem_grant,
    input  logic [31:0]      mem_rd,
    output logic [31:0]      mem_a,
    output logic             mem_we,
    output logic [31:0]      mem_wd,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             err_q, err_d;

    // Request-side and latched view of the fill feature.
    logic             req_fill;
    logic             fill_mode;
    logic [31:0]      wr_data;

`ifdef DMEM_DMA_FILL_EN
    logic             mode_q, mode_d;
    logic [31:0]      fill_q, fill_d;

    assign req_fill  = mode;
    assign fill_mode = mode_q;
    assign wr_data   = mode_q ? fill_q : data_q;
`else
    // mode and fill_val have no function in a copy-only build.
    logic             unused_cfg;

    assign unused_cfg = mode ^ (^fill_val);
    assign req_fill   = 1'b0;
    assign fill_mode  = 1'b0;
    assign wr_data    = data_q;
`endif

    logic misaligned;

    // Source alignment matters only when the source is actually read.
    assign misaligned = (~req_fill & (|src[1:0])) | (|dst[1:0]);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef DMEM_DMA_FILL_EN
        mode_d  = mode_q;
        fill_d  = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src;
                    dst_d = dst;
                    cnt_d = len;
                    err_d = 1'b0;
`ifdef DMEM_DMA_FILL_EN
                    mode_d = mode;
                    fill_d = fill_val;
`endif
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (len == '0) begin
                        state_d = S_FIN;
                    end else if (req_fill) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (mem_grant) begin
                    data_d  = mem_rd;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (mem_grant) begin
                    src_d = src_q + 32'd4;
                    dst_d = dst_q + 32'd4;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_FIN;
                    end else if (fill_mode) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_DMA_FILL_EN
            mode_q  <= 1'b0;
            fill_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef DMEM_DMA_FILL_EN
            mode_q  <= mode_d;
            fill_q  <= fill_d;
`endif
        end
    end

    // Outputs are decoded from the state flop so reset clears them at once.
    assign busy   = (state_q == S_RD) || (state_q == S_WR);
    assign done   = (state_q == S_FIN);
    assign err    = err_q;
    assign mem_we = (state_q == S_WR) && mem_grant;
    assign mem_a  = (state_q == S_RD) ? src_q :
                    (state_q == S_WR) ? dst_q : 32'd0;
    assign mem_wd = (state_q == S_WR) ? wr_data : 32'd0;

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: memory model, write scoreboard and
// cycle-accurate busy/done/err expectations for each transfer.
module tb_dmem_dma;

`ifdef DMEM_DMA_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [7:0]  len = '0;
    logic [31:0] fill_val = '0;
    logic        grant = 1'b1;
    logic [31:0] mem_rd;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic        busy;
    logic        done;
    logic        err;

    dmem_dma #(.LEN_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_val  (fill_val),
        .mem_grant (grant),
        .mem_rd    (mem_rd),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_a  = '0;
    logic [31:0] pl_d  = '0;

    assign mem_rd = mem[mem_a[11:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[11:2]] <= mem_wd;
        else if (pl_we) mem[pl_a] <= pl_d;
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  n_tot = 0;
    int  n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexp_we", mem_a, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", mem_a, mon_e.a);
                chk("wr_data", mem_wd, mon_e.d);
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    // One transfer. gs/gl: grant low for gl cycles from cycle gs.
    // ign_at: stray start pulse in that cycle. rst_at: reset in that cycle.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                           input logic m, input logic [31:0] fv,
                           input int gs, input int gl, input int ign_at, input int rst_at,
                           input string tag);
        logic       fillm;
        logic       mis;
        int         nw, nlim, nchk, exp_done, done_cyc, busy_cnt;
        wr_t        e;
        logic [9:0] si, di;
        logic [31:0] v;

        fillm = FILL_ON && m;
        mis   = (!fillm && (s[1:0] != 2'b00)) || (d[1:0] != 2'b00);
        nw    = (mis || n == 8'd0) ? 0 : int'(n);
        nlim  = (rst_at > 0 && nw > 2) ? 2 : nw;
        for (int i = 0; i < nlim; i++) begin
            si = s[11:2] + 10'(i);
            di = d[11:2] + 10'(i);
            v  = fillm ? fv : ref_mem[si];
            ref_mem[di] = v;
            e.a = d + 32'(4 * i);
            e.d = v;
            sb.push_back(e);
        end
        exp_done = (nw == 0) ? 1 : ((fillm ? nw + 1 : 2 * nw + 1) + gl);

        @(negedge clk);
        src = s; dst = d; len = n; mode = m; fill_val = fv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 1200; k++) begin
            grant = !(gl > 0 && k >= gs && k < gs + gl);
            if (k == ign_at) begin
                start = 1'b1; src = 32'h300; dst = 32'h304; len = 8'd7; mode = ~m;
            end else if (k == ign_at + 1) begin
                start = 1'b0;
            end
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                chk({tag, "_rst_we"}, mem_we, 0);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_done"}, done, 0);
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            @(negedge clk);
            if (!grant) chk({tag, "_stall_we"}, mem_we, 0);
            if (k == 1) chk({tag, "_err"}, err, mis);
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        grant = 1'b1;
        start = 1'b0;
        if (rst_at == 0) begin
            chk({tag, "_done_cyc"}, done_cyc, exp_done);
            chk({tag, "_busy_cnt"}, busy_cnt, exp_done - 1);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
        end
        #1;
        chk({tag, "_sb_left"}, sb.size(), 0);
        sb.delete();
        nchk = (rst_at > 0) ? int'(n) : nw;
        for (int i = 0; i < nchk; i++) begin
            di = d[11:2] + 10'(i);
            chk({tag, "_mem"}, mem[di], ref_mem[di]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 1024; i++) poke(10'(i), $urandom);
        poke(10'd4, 32'h11);
        poke(10'd5, 32'h22);
        poke(10'd6, 32'h33);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_job(32'h10, 32'h40, 8'd3, 1'b0, 32'h0, 0, 0, 0, 0, "copy3");
        chk("copy3_w40", mem[16], 32'h11);
        chk("copy3_w48", mem[18], 32'h33);
        run_job(32'h10, 32'h80, 8'd4, 1'b1, 32'hDEADBEEF, 0, 0, 0, 0, "mode1");
        run_job(32'h10, 32'hC0, 8'd2, 1'b0, 32'h0, 2, 3, 0, 0, "stall");
        run_job(32'h10, 32'hE0, 8'd0, 1'b0, 32'h0, 0, 0, 0, 0, "len0");
        run_job(32'h12, 32'hE0, 8'd2, 1'b0, 32'h0, 0, 0, 0, 0, "mis_src");
        chk("mis_src_sticky", err, 1);
        run_job(32'h20, 32'h100, 8'd2, 1'b0, 32'h0, 0, 0, 0, 0, "clr_err");
        run_job(32'h20, 32'h102, 8'd2, 1'b0, 32'h0, 0, 0, 0, 0, "mis_dst");
        run_job(32'h10, 32'h140, 8'd4, 1'b0, 32'h0, 0, 0, 0, 5, "rst_mid");
        run_job(32'h10, 32'h180, 8'd3, 1'b0, 32'h0, 0, 0, 3, 0, "ign_start");
        run_job(32'h200, 32'h204, 8'd3, 1'b0, 32'h0, 0, 0, 0, 0, "smear");
        run_job(32'h0, 32'h400, 8'd255, 1'b0, 32'h0, 0, 0, 0, 0, "maxlen");
        for (int j = 0; j < 4; j++) begin
            run_job({20'd0, 10'($urandom_range(0, 100)), 2'b00},
                    {20'd0, 10'($urandom_range(600, 900)), 2'b00},
                    8'($urandom_range(1, 6)), 1'b0, 32'h0,
                    2, int'($urandom_range(0, 2)), 0, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
